// File: rtl/if_stage_ibuf.sv
// Fetch stage with split req/resp instruction SRAM port and an IB_DEPTH-entry
// instruction buffer. Handles delay slots, taken-branch redirect and flush.
module if_stage_ibuf #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int unsigned IB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned PW = $clog2(IB_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic        br_leave;
  logic        br_taken;
  logic [31:0] br_target;

  logic [31:0] buf_pc   [IB_DEPTH];
  logic [31:0] buf_inst [IB_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [31:0] fetch_pc;
  logic [31:0] ipc;
  logic        outstanding;
  logic        discard;
  logic        bd_pending;
  logic        redir_pending;
  logic [31:0] redir_pc;
  logic        kill_pending;
  logic [31:0] kill_pc;

  logic        empty;
  logic        taken;
  logic        drop_younger;
  logic        squash;
  logic [31:0] redirect_pc;
  logic        pop;
  logic        accept;
  logic        resp;
  logic        push;

  assign br_leave  = br_bus[33];
  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wdata = '0;
  assign inst_sram_addr  = fetch_pc;

  always_comb begin
    empty          = (count == '0);
    taken          = br_leave && br_taken && !flush;
    drop_younger   = taken && !empty;
    squash         = flush || drop_younger;
    redirect_pc    = flush ? flush_pc : br_target;
    fs_to_ds_valid = !empty && !flush;
    pop            = fs_to_ds_valid && ds_allowin;
    inst_sram_req  = !reset && !outstanding &&
                     ((count + CW'(outstanding)) < CW'(IB_DEPTH));
    accept         = inst_sram_req && inst_sram_addr_ok;
    resp           = outstanding && inst_sram_data_ok;
    push           = resp && !discard && !squash;
  end

  always_comb begin
    fs_to_ds_bus = '0;
    if (fs_to_ds_valid) begin
      fs_to_ds_bus = {br_leave | bd_pending, buf_inst[rd_ptr], buf_pc[rd_ptr]};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= ipc;
      buf_inst[wr_ptr] <= inst_sram_rdata;
    end
  end

  // A taken branch keeps only the head (the delay slot), or nothing if it pops now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else if (drop_younger) begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        wr_ptr <= rd_ptr + PW'(1);
        count  <= '0;
      end else begin
        wr_ptr <= rd_ptr + PW'(1);
        count  <= CW'(1);
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A request already on the bus must keep its address until accepted; a
  // redirect that arrives meanwhile is parked in kill_pc and applied at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc      <= RESET_PC;
      ipc           <= '0;
      outstanding   <= 1'b0;
      discard       <= 1'b0;
      redir_pending <= 1'b0;
      redir_pc      <= '0;
      kill_pending  <= 1'b0;
      kill_pc       <= '0;
    end else if (accept) begin
      outstanding <= 1'b1;
      ipc         <= fetch_pc;
      if (squash) begin
        discard       <= 1'b1;
        fetch_pc      <= redirect_pc;
        kill_pending  <= 1'b0;
        redir_pending <= 1'b0;
      end else if (kill_pending) begin
        discard      <= 1'b1;
        fetch_pc     <= kill_pc;
        kill_pending <= 1'b0;
        if (taken) begin
          redir_pending <= 1'b1;
          redir_pc      <= br_target;
        end
      end else if (taken) begin
        fetch_pc      <= br_target;
        redir_pending <= 1'b0;
      end else if (redir_pending) begin
        fetch_pc      <= redir_pc;
        redir_pending <= 1'b0;
      end else begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end else begin
      if (resp) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      if (squash) begin
        if (outstanding && !inst_sram_data_ok) discard <= 1'b1;
        if (inst_sram_req) begin
          kill_pending <= 1'b1;
          kill_pc      <= redirect_pc;
        end else begin
          fetch_pc <= redirect_pc;
        end
        if (flush) redir_pending <= 1'b0;
      end else if (taken) begin
        if (outstanding) begin
          fetch_pc <= br_target;
        end else begin
          redir_pending <= 1'b1;
          redir_pc      <= br_target;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd_pending <= 1'b0;
    end else if (flush || pop) begin
      bd_pending <= 1'b0;
    end else if (br_leave) begin
      bd_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage_ibuf.sv
// Randomized bench for if_stage_ibuf: an SRAM responder plus a program-order
// model that predicts every delivered {bd, inst, pc}.
module tb_if_stage_ibuf;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b0;
  logic [33:0] br_bus = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  if_stage_ibuf #(.RESET_PC(RESET_PC), .IB_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // stimulus knobs
  int unsigned aok_pct, allow_pct, flush_pm, br_pct, lat_min, lat_max;
  logic        force_flush, force_br, force_taken;
  logic [31:0] force_fpc, force_tgt;

  // program-order model and responder state
  logic [31:0] exp_pc;
  logic        dly, dly_taken, br_cand;
  logic [31:0] dly_tgt;
  logic        hold_pend;
  logic [31:0] hold_addr;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int unsigned mem_lat;
  int unsigned n_pop, n_resp;
  logic [31:0] pops_q[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic step();
    logic        br_l, br_t, pop, was_ds;
    logic [31:0] br_tg;
    @(negedge clk);
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = $urandom;
    if (mem_busy && mem_lat == 0) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_f(mem_addr);
    end
    inst_sram_addr_ok = inst_sram_req && !mem_busy && ($urandom_range(99) < aok_pct);
    ds_allowin = ($urandom_range(99) < allow_pct);
    flush      = force_flush || ($urandom_range(999) < flush_pm);
    flush_pc   = force_flush ? force_fpc : RESET_PC + ($urandom_range(1023) << 2);
    br_l  = force_br || (br_cand && ($urandom_range(99) < br_pct));
    br_t  = force_br ? force_taken : 1'($urandom_range(1));
    br_tg = force_br ? force_tgt : 32'h80000000 + ($urandom_range(1023) << 2);
    br_bus = {br_l, br_t, br_tg};
    #1;
    if (flush) check_eq("flush_valid", 32'(fs_to_ds_valid), 32'd0);
    if (hold_pend) begin
      check_eq("req_hold", 32'(inst_sram_req), 32'd1);
      check_eq("addr_hold", inst_sram_addr, hold_addr);
    end
    if (br_l) begin
      dly = 1'b1; dly_taken = br_t; dly_tgt = br_tg; br_cand = 1'b0;
    end
    pop = fs_to_ds_valid && ds_allowin;
    if (flush) begin
      exp_pc = flush_pc; dly = 1'b0; br_cand = 1'b0;
    end else if (pop) begin
      check_eq("pc", fs_to_ds_bus[31:0], exp_pc);
      check_eq("inst", fs_to_ds_bus[63:32], mem_f(exp_pc));
      check_eq("bd", 32'(fs_to_ds_bus[64]), 32'(dly));
      pops_q.push_back(fs_to_ds_bus[31:0]);
      n_pop++;
      was_ds  = dly;
      exp_pc  = (dly && dly_taken) ? dly_tgt : exp_pc + 32'd4;
      dly     = 1'b0;
      br_cand = !was_ds;
    end
    hold_pend = inst_sram_req && !inst_sram_addr_ok;
    hold_addr = inst_sram_addr;
    if (inst_sram_data_ok) begin
      mem_busy = 1'b0; n_resp++;
    end else if (mem_busy && mem_lat > 0) begin
      mem_lat--;
    end
    if (inst_sram_addr_ok) begin
      mem_busy = 1'b1; mem_addr = inst_sram_addr;
      mem_lat  = $urandom_range(lat_max, lat_min);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    flush = 1'b0; br_bus = '0; ds_allowin = 1'b0;
    #1;
    check_eq("rst_valid", 32'(fs_to_ds_valid), 32'd0);
    check_eq("rst_req", 32'(inst_sram_req), 32'd0);
    check_eq("rst_bus", fs_to_ds_bus[31:0], 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_pc = RESET_PC; dly = 1'b0; dly_taken = 1'b0; dly_tgt = '0; br_cand = 1'b0;
    hold_pend = 1'b0; mem_busy = 1'b0; mem_lat = 0; n_pop = 0; n_resp = 0;
    pops_q.delete();
    force_flush = 1'b0; force_br = 1'b0; force_taken = 1'b0;
    #1;
    check_eq("rel_req", 32'(inst_sram_req), 32'd1);
    check_eq("rel_addr", inst_sram_addr, RESET_PC);
  endtask

  task automatic set_knobs(input int unsigned aok, input int unsigned allow,
                           input int unsigned lmin, input int unsigned lmax);
    aok_pct = aok; allow_pct = allow; lat_min = lmin; lat_max = lmax;
    flush_pm = 0; br_pct = 0;
  endtask

  initial begin
    int unsigned k;
    logic [31:0] x;
    force_fpc = '0; force_tgt = '0;
    set_knobs(100, 100, 0, 0);

    // sequential delivery
    do_reset();
    set_knobs(100, 100, 0, 0);
    repeat (12) step();
    check_eq("t1_npop", 32'(pops_q.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      if (i < pops_q.size()) check_eq("t1_pc", pops_q[i], RESET_PC + 32'(4 * i));

    // fill to depth, then drain
    do_reset();
    set_knobs(100, 0, 0, 0);
    repeat (12) step();
    check_eq("t2_resp", n_resp, 32'd4);
    check_eq("t2_req_full", 32'(inst_sram_req), 32'd0);
    allow_pct = 100;
    repeat (4) step();
    check_eq("t2_drain", n_pop, 32'd4);
    repeat (10) step();

    // flush with a response in flight
    do_reset();
    set_knobs(100, 100, 5, 5);
    repeat (2) step();
    force_flush = 1'b1; force_fpc = 32'hbfc00380;
    step();
    force_flush = 1'b0;
    repeat (25) step();
    check_eq("t3_npop", 32'(pops_q.size() >= 1), 32'd1);
    if (pops_q.size() >= 1) check_eq("t3_first", pops_q[0], 32'hbfc00380);

    // taken branch with younger entries buffered
    do_reset();
    set_knobs(100, 100, 0, 0);
    for (int i = 0; i < 20 && n_pop == 0; i++) step();
    allow_pct = 0;
    repeat (6) step();
    force_br = 1'b1; force_taken = 1'b1; force_tgt = 32'h80001000;
    step();
    force_br = 1'b0;
    allow_pct = 100;
    repeat (15) step();
    check_eq("t4_npop", 32'(pops_q.size() >= 3), 32'd1);
    if (pops_q.size() >= 3) begin
      check_eq("t4_ds", pops_q[1], RESET_PC + 32'd4);
      check_eq("t4_tgt", pops_q[2], 32'h80001000);
    end

    // taken branch with empty buffer and unaccepted request
    do_reset();
    set_knobs(100, 100, 0, 0);
    for (int i = 0; i < 20 && n_pop == 0; i++) step();
    aok_pct = 0;
    repeat (8) step();
    k = pops_q.size();
    x = exp_pc;
    force_br = 1'b1; force_taken = 1'b1; force_tgt = 32'h80002000;
    step();
    force_br = 1'b0;
    aok_pct = 100;
    repeat (12) step();
    check_eq("t5_npop", 32'(pops_q.size() >= k + 2), 32'd1);
    if (pops_q.size() >= k + 2) begin
      check_eq("t5_ds", pops_q[k], x);
      check_eq("t5_tgt", pops_q[k+1], 32'h80002000);
    end

    // async reset during a response
    do_reset();
    set_knobs(100, 100, 3, 3);
    for (int i = 0; i < 10 && !mem_busy; i++) step();
    step();
    do_reset();
    set_knobs(100, 100, 0, 2);
    repeat (10) step();
    check_eq("t6_npop", 32'(pops_q.size() >= 1), 32'd1);
    if (pops_q.size() >= 1) check_eq("t6_first", pops_q[0], RESET_PC);

    // randomized traffic with branches and flushes
    do_reset();
    for (int b = 0; b < 40; b++) begin
      aok_pct   = $urandom_range(100, 30);
      allow_pct = $urandom_range(100, 20);
      lat_min   = 0;
      lat_max   = $urandom_range(4);
      flush_pm  = $urandom_range(30);
      br_pct    = $urandom_range(40);
      repeat (60) step();
    end
    check_eq("rand_progress", 32'(n_pop > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
